// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the key schedule and round datapath:
//   AES_NROUNDS  - number of rounds after the initial key (AES-128 only)
//   AES_RND_W    - width of a round index (0..10 fits in 4 bits)
//   aes_word_t   - 32-bit key/state word, bits[31:24] hold the first byte
//   AES_RCON     - round constants, indexed by round number 1..10
//   aes_rcon()   - range-safe round-constant lookup (0 outside 1..10)
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_NROUNDS = 10;
    localparam int AES_RND_W   = 4;

    typedef logic [31:0] aes_word_t;

    typedef enum logic [0:0] {
        KS_IDLE = 1'b0,
        KS_EMIT = 1'b1
    } aes_ks_state_e;

    localparam logic [7:0] AES_RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Index values outside 1..10 can appear on the combinational path while
    // the last key is presented; they map to zero instead of an out-of-range read.
    function automatic logic [7:0] aes_rcon(input logic [AES_RND_W-1:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = AES_RCON[1];
            4'd2:    rc = AES_RCON[2];
            4'd3:    rc = AES_RCON[3];
            4'd4:    rc = AES_RCON[4];
            4'd5:    rc = AES_RCON[5];
            4'd6:    rc = AES_RCON[6];
            4'd7:    rc = AES_RCON[7];
            4'd8:    rc = AES_RCON[8];
            4'd9:    rc = AES_RCON[9];
            4'd10:   rc = AES_RCON[10];
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Combinational forward AES S-box (FIPS-197 SubBytes table), one byte wide.
//   din   in  8  input byte
//   dout  out 8  substituted byte
// -----------------------------------------------------------------------------
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [7:0] SBOX_TABLE [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX_TABLE[din];

endmodule

// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand
// Iterative AES-128 key schedule. Loads a cipher key on start and presents
// round keys 0..10 in order over a valid/ready handshake, producing each next
// key in a single cycle (one key per cycle when the consumer stays ready).
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous active-low reset
//   start      in   1   load key_in0..3 and begin (honoured only when idle)
//   key_in0..3 in   32  cipher key words w[0]..w[3]
//   busy       out  1   high from the cycle after start until the last handshake
//   rk_valid   out  1   rk0..rk3 / rk_round hold a valid round key
//   rk_ready   in   1   consumer accepts the presented round key
//   rk_round   out  4   index of the presented round key, 0..10
//   rk0..rk3   out  32  round-key words feeding key0..key3 of the round stage
//   done       out  1   one-cycle pulse after round key 10 is accepted
// -----------------------------------------------------------------------------
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NROUNDS = AES_NROUNDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] key_in0,
    input  logic [31:0] key_in1,
    input  logic [31:0] key_in2,
    input  logic [31:0] key_in3,
    output logic        busy,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [3:0]  rk_round,
    output logic [31:0] rk0,
    output logic [31:0] rk1,
    output logic [31:0] rk2,
    output logic [31:0] rk3,
    output logic        done
);

    localparam logic [AES_RND_W-1:0] LAST_ROUND = AES_RND_W'(NROUNDS);

    aes_ks_state_e          state_r;
    aes_ks_state_e          next_state_s;

    aes_word_t              w0_r, w1_r, w2_r, w3_r;
    logic [AES_RND_W-1:0]   rk_round_r;
    logic                   busy_r;
    logic                   rk_valid_r;
    logic                   done_r;

    aes_word_t              w0_d_s, w1_d_s, w2_d_s, w3_d_s;
    logic [AES_RND_W-1:0]   rk_round_d_s;
    logic                   busy_d_s;
    logic                   rk_valid_d_s;
    logic                   done_d_s;

    logic                   hs_s;
    logic                   last_s;
    aes_word_t              rot_s;
    aes_word_t              sub_s;
    logic [7:0]             rcon_s;
    aes_word_t              temp_s;
    aes_word_t              nk0_s, nk1_s, nk2_s, nk3_s;

    assign hs_s   = rk_valid_r & rk_ready;
    assign last_s = (rk_round_r == LAST_ROUND);

    // Next round key from the presented one: RotWord, SubWord, Rcon, then
    // the chained XOR across the four words.
    assign rot_s = {w3_r[23:0], w3_r[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (rot_s[8*i +: 8]),
            .dout (sub_s[8*i +: 8])
        );
    end

    assign rcon_s = aes_rcon(rk_round_r + 4'd1);
    assign temp_s = sub_s ^ {rcon_s, 24'h000000};
    assign nk0_s  = w0_r ^ temp_s;
    assign nk1_s  = w1_r ^ nk0_s;
    assign nk2_s  = w2_r ^ nk1_s;
    assign nk3_s  = w3_r ^ nk2_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= KS_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode: leave IDLE on start, return after the last handshake.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            KS_IDLE: begin
                if (start) begin
                    next_state_s = KS_EMIT;
                end else begin
                    next_state_s = KS_IDLE;
                end
            end
            KS_EMIT: begin
                if (hs_s && last_s) begin
                    next_state_s = KS_IDLE;
                end else begin
                    next_state_s = KS_EMIT;
                end
            end
            default: next_state_s = KS_IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs; everything holds
    // unless a load or handshake changes it, and done is a single-cycle pulse.
    always_comb begin
        w0_d_s       = w0_r;
        w1_d_s       = w1_r;
        w2_d_s       = w2_r;
        w3_d_s       = w3_r;
        rk_round_d_s = rk_round_r;
        busy_d_s     = busy_r;
        rk_valid_d_s = rk_valid_r;
        done_d_s     = 1'b0;
        case (state_r)
            KS_IDLE: begin
                if (start) begin
                    w0_d_s       = key_in0;
                    w1_d_s       = key_in1;
                    w2_d_s       = key_in2;
                    w3_d_s       = key_in3;
                    rk_round_d_s = 4'd0;
                    busy_d_s     = 1'b1;
                    rk_valid_d_s = 1'b1;
                end else begin
                    busy_d_s     = 1'b0;
                    rk_valid_d_s = 1'b0;
                end
            end
            KS_EMIT: begin
                if (hs_s) begin
                    if (last_s) begin
                        // Last key words and index stay visible after done.
                        busy_d_s     = 1'b0;
                        rk_valid_d_s = 1'b0;
                        done_d_s     = 1'b1;
                    end else begin
                        w0_d_s       = nk0_s;
                        w1_d_s       = nk1_s;
                        w2_d_s       = nk2_s;
                        w3_d_s       = nk3_s;
                        rk_round_d_s = rk_round_r + 4'd1;
                    end
                end else begin
                    done_d_s = 1'b0;
                end
            end
            default: begin
                busy_d_s     = 1'b0;
                rk_valid_d_s = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w0_r       <= 32'h0000_0000;
            w1_r       <= 32'h0000_0000;
            w2_r       <= 32'h0000_0000;
            w3_r       <= 32'h0000_0000;
            rk_round_r <= 4'd0;
            busy_r     <= 1'b0;
            rk_valid_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            w0_r       <= w0_d_s;
            w1_r       <= w1_d_s;
            w2_r       <= w2_d_s;
            w3_r       <= w3_d_s;
            rk_round_r <= rk_round_d_s;
            busy_r     <= busy_d_s;
            rk_valid_r <= rk_valid_d_s;
            done_r     <= done_d_s;
        end
    end

    assign rk0      = w0_r;
    assign rk1      = w1_r;
    assign rk2      = w2_r;
    assign rk3      = w3_r;
    assign rk_round = rk_round_r;
    assign busy     = busy_r;
    assign rk_valid = rk_valid_r;
    assign done     = done_r;

endmodule

// File: tb/tb_aes_key_expand.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expand
// Self-checking bench for aes_key_expand. The reference derives the S-box from
// GF(2^8) inversion plus the affine map, expands keys with the textbook w[0..43]
// loop, and tracks the handshake protocol at transaction level; a negedge
// process compares every output every cycle.
// -----------------------------------------------------------------------------
module tb_aes_key_expand;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rk_ready = 1'b0;
    logic [31:0] key_in0 = 32'h0, key_in1 = 32'h0, key_in2 = 32'h0, key_in3 = 32'h0;
    logic        busy, rk_valid, done;
    logic [3:0]  rk_round;
    logic [31:0] rk0, rk1, rk2, rk3;

    aes_key_expand #(.NROUNDS(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in0  (key_in0),
        .key_in1  (key_in1),
        .key_in2  (key_in2),
        .key_in3  (key_in3),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_round (rk_round),
        .rk0      (rk0),
        .rk1      (rk1),
        .rk2      (rk2),
        .rk3      (rk3),
        .done     (done)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    bit          chk_en = 1'b0;
    logic [7:0]  model_sbox [0:255];
    logic [127:0] cap [0:10];

    // Transaction-level reference state.
    bit          m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_loaded = 1'b0;
    int          m_round = 0;
    logic [127:0] m_key = 128'h0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363_62636363_62636363_62636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {model_sbox[temp[31:24]], model_sbox[temp[23:16]],
                        model_sbox[temp[15:8]], model_sbox[temp[7:0]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Reference protocol: idle until start, then one key per accepted handshake.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
            m_round <= 0; m_loaded <= 1'b0; m_key <= 128'h0;
        end else begin
            m_done <= 1'b0;
            if (!m_valid) begin
                if (start) begin
                    m_key <= {key_in0, key_in1, key_in2, key_in3};
                    m_loaded <= 1'b1; m_round <= 0;
                    m_valid <= 1'b1; m_busy <= 1'b1;
                end
            end else if (rk_ready) begin
                if (m_round == 10) begin
                    m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1;
                end else begin
                    m_round <= m_round + 1;
                end
            end
        end
    end

    // Every-cycle compare against the reference, plus capture of presented keys.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [127:0] exp_words;
            exp_words = m_loaded ? round_key(m_key, m_round) : 128'h0;
            chk("rk_valid", {127'h0, rk_valid}, {127'h0, m_valid});
            chk("busy", {127'h0, busy}, {127'h0, m_busy});
            chk("done", {127'h0, done}, {127'h0, m_done});
            chk("rk_round", {124'h0, rk_round}, 128'(m_round));
            chk("rk_words", {rk0, rk1, rk2, rk3}, exp_words);
            if (rk_valid && rk_round <= 4'd10) cap[rk_round] = {rk0, rk1, rk2, rk3};
        end
    end

    // mode 0: rk_ready held high; 1: random ready; 2: random ready + stray starts.
    task automatic run_key(input logic [127:0] key, input int mode, output int cycles);
        bit got_done = 1'b0;
        {key_in0, key_in1, key_in2, key_in3} = key;
        start = 1'b1;
        if (mode == 0) rk_ready = 1'b1;
        cycles = 0;
        while (!got_done && cycles < 400) begin
            @(posedge clk); #2;
            cycles++;
            if (cycles == 1) begin
                chk("first_valid", {127'h0, rk_valid}, 128'h1);
                chk("first_round", {124'h0, rk_round}, 128'h0);
                chk("round0_key", {rk0, rk1, rk2, rk3}, key);
            end
            start = 1'b0;
            if (mode != 0) rk_ready = 1'($urandom_range(0, 1));
            if (mode == 2) begin
                start = 1'($urandom_range(0, 1));
                {key_in0, key_in1, key_in2, key_in3} = {$urandom, $urandom, $urandom, $urandom};
            end
            got_done = done;
        end
        start = 1'b0;
        if (!got_done) chk("done_timeout", 128'h0, 128'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) model_sbox[i] = sbox_ref(8'(i));

        // Pin the reference against published values.
        chk("model_sbox00", 128'(model_sbox[8'h00]), 128'h63);
        chk("model_sbox53", 128'(model_sbox[8'h53]), 128'hed);
        chk("model_fips_r1", round_key(FIPS_KEY, 1), FIPS_R1);
        chk("model_fips_r10", round_key(FIPS_KEY, 10), FIPS_R10);
        chk("model_zero_r1", round_key(128'h0, 1), ZERO_R1);
        chk("model_zero_r10", round_key(128'h0, 10), ZERO_R10);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b1;
        chk("reset_outputs", {rk0, rk1, rk2, rk3}, 128'h0);
        chk("reset_flags", {124'h0, busy, rk_valid, done, 1'b0}, 128'h0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // FIPS-197 key, consumer always ready.
        run_key(FIPS_KEY, 0, cyc);
        chk("fips_done_latency", 128'(cyc), 128'd12);
        chk("fips_r1", cap[1], FIPS_R1);
        chk("fips_r10", cap[10], FIPS_R10);
        repeat (2) @(posedge clk); #2;

        // Same key with random backpressure, then with stray starts.
        run_key(FIPS_KEY, 1, cyc);
        chk("bp_r10", cap[10], FIPS_R10);
        @(posedge clk); #2;
        run_key(FIPS_KEY, 2, cyc);
        chk("stray_start_r1", cap[1], FIPS_R1);
        chk("stray_start_r10", cap[10], FIPS_R10);
        @(posedge clk); #2;

        // Reset while round key 5 is presented.
        {key_in0, key_in1, key_in2, key_in3} = FIPS_KEY;
        rk_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (rk_round == 4'd5) break;
        end
        chk("reached_round5", {124'h0, rk_round}, 128'd5);
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        chk("abort_words", {rk0, rk1, rk2, rk3}, 128'h0);
        chk("abort_flags", {120'h0, rk_round, busy, rk_valid, done, 1'b0}, 128'h0);
        @(posedge clk); #2;
        chk("abort_no_done", {127'h0, done}, 128'h0);
        run_key(FIPS_KEY, 0, cyc);
        chk("after_abort_r1", cap[1], FIPS_R1);

        // Start in the done cycle: all-zero key accepted immediately.
        run_key(128'h0, 0, cyc);
        chk("done_cycle_latency", 128'(cyc), 128'd12);
        chk("zero_r1", cap[1], ZERO_R1);
        chk("zero_r10", cap[10], ZERO_R10);
        @(posedge clk); #2;

        // Random keys under random backpressure and stray starts.
        for (int k = 0; k < 6; k++) begin
            run_key({$urandom, $urandom, $urandom, $urandom}, 1 + (k % 2), cyc);
            repeat (k % 3) @(posedge clk);
            #2;
        end

        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key-schedule stage, directly upstream of the round stage.
- Drives the round stage's four 32-bit round-key inputs (key0..key3 word order).
- Accepts a 128-bit cipher key and emits round keys 0..10 in order, one per valid/ready handshake.
- Computes each next round key in a single cycle, so throughput is one key per cycle when the consumer is always ready.

Parameters:
- NROUNDS, 10, number of rounds after the initial key; 10 is the only legal value (AES-128).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset; synchronous and active-low.
- start  in  1  load key_in0..3 and begin expansion; honoured only in IDLE.
- key_in0  in  32  cipher key word w[0], bits[31:24] are the first key byte.
- key_in1  in  32  cipher key word w[1].
- key_in2  in  32  cipher key word w[2].
- key_in3  in  32  cipher key word w[3].
- busy  out  1  high from the cycle after an accepted start until the last handshake.
- rk_valid  out  1  rk0..rk3 and rk_round hold a valid round key.
- rk_ready  in  1  consumer accepts the current round key.
- rk_round  out  4  index of the presented round key, 0..10.
- rk0  out  32  round-key word 0 (feeds key0 of the round stage).
- rk1  out  32  round-key word 1 (feeds key1).
- rk2  out  32  round-key word 2 (feeds key2).
- rk3  out  32  round-key word 3 (feeds key3).
- done  out  1  one-cycle pulse after round key 10 is accepted.

Behaviour:
- States: IDLE and EMIT.
- Reset (rst_n low at a clk edge): state=IDLE; busy, rk_valid and done = 0; rk_round=0; rk0..rk3=0. Reset mid-expansion aborts immediately with no done pulse.
- IDLE with start=1 at edge t:
  - Latch key_in0..3 into rk0..rk3; rk_round=0.
  - rk_valid=1 and busy=1 from cycle t+1.
  - State becomes EMIT.
- EMIT with rk_valid=1 and rk_ready=0: all outputs hold unchanged.
- EMIT with a handshake (rk_valid and rk_ready) and rk_round<10:
  - At the same edge, register the next key and increment rk_round.
  - rk_valid stays high, so keys are back-to-back.
- Next-key arithmetic, from the registered words w0..w3:
  - rot = {w3[23:0], w3[31:24]}.
  - sub = S-box applied to each byte of rot.
  - t = sub ^ {rcon[r], 24'h0}, where r = rk_round+1.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- EMIT with a handshake and rk_round==10:
  - Next cycle: rk_valid=0, busy=0, done=1 for exactly one cycle; state=IDLE.
  - rk0..rk3 and rk_round keep the last values.
- start is ignored while in EMIT; a start in the done cycle is accepted (that cycle is IDLE).
- Latency: start to round key 0 = 1 cycle. With rk_ready held high, start to done = 12 cycles.
- rk_ready is don't-care when rk_valid=0.

Decomposition:
- Shared package aes_pkg:
  - AES_NROUNDS=10.
  - RCON constant array indexed 1..10.
  - 32-bit word typedef.
  - Round-index width constant (4).
- Sub-module aes_sbox: combinational 8-bit forward S-box lookup. Instantiated 4 times here; reusable by subbytes.

Test Plan:
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, start pulsed, rk_ready=1:
  - round0 = input key.
  - round1 = a0fafe17 88542cb1 23a33939 2a6c7605.
  - round10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - done exactly 12 cycles after start.
- Same key, rk_ready toggled randomly: identical 11-key sequence; outputs stable while rk_ready=0; rk_round advances only on handshakes.
- start pulsed during EMIT with a different key: ignored; sequence and round10 value unchanged.
- rst_n low at round 5: next cycle all outputs 0 and state IDLE, no done pulse; a fresh start then yields round1 = a0fafe17 88542cb1 23a33939 2a6c7605.
- Key all-zero: round1 = 62636363 62636363 62636363 62636363; round10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
- start asserted in the done cycle: accepted; round0 is presented on the following cycle.
